// File: rtl/div_f_norm_pack_pkg.sv
// Shared constants and types for the divider normalize/round/pack block.
package div_f_norm_pack_pkg;

  localparam int unsigned MANT_W_DEF = 27;  // 24 significand bits + guard, round, sticky
  localparam int unsigned EXP_W_DEF  = 10;  // signed biased exponent width
  localparam int unsigned BIAS       = 127;
  localparam int unsigned EXP_MAX    = 255;
  localparam int unsigned FRAC_W     = 23;
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  // Assemble an IEEE-754 single from its fields.
  function automatic logic [31:0] pack_f32(input logic sign, input logic [7:0] exp,
                                           input logic [FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/div_f_norm_pack_norm_shift.sv
// Leading-zero count and left shift that brings the mantissa's leading one to the MSB.
module norm_shift #(
  parameter int unsigned MANT_W = 27,
  parameter int unsigned LZ_W   = 5
) (
  input  logic [MANT_W-1:0] mant,
  output logic [LZ_W-1:0]   lz,
  output logic [MANT_W-1:0] mant_n
);

  logic found;

  // Priority search from the MSB; an all-zero mantissa yields lz = MANT_W.
  always_comb begin
    lz    = LZ_W'(MANT_W);
    found = 1'b0;
    for (int i = int'(MANT_W) - 1; i >= 0; i--) begin
      if (!found && mant[i]) begin
        lz    = LZ_W'(int'(MANT_W) - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign mant_n = mant << lz;

endmodule

// File: rtl/div_f_norm_pack.sv
// Two-stage divider back end: S1 normalizes, S2 rounds (RNE) and packs to IEEE-754 single.
module div_f_norm_pack
  import div_f_norm_pack_pkg::*;
#(
  parameter int unsigned MANT_W = MANT_W_DEF,
  parameter int unsigned EXP_W  = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_nan,
  input  logic              in_inf,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [2:0]        out_flags
);

  localparam int unsigned LZ_W  = $clog2(MANT_W + 1);
  localparam int unsigned SIG_W = MANT_W - 3;
  localparam logic signed [EXP_W+1:0] EXP_OVF = (EXP_W+2)'(EXP_MAX);

  // S1 state
  logic              s1_valid;
  logic              s1_sign;
  logic              s1_nan;
  logic              s1_inf;
  logic              s1_zero;
  logic [EXP_W:0]    s1_exp;
  logic [MANT_W-1:0] s1_mant;

  // Normalizer outputs
  logic [LZ_W-1:0]   lz;
  logic [MANT_W-1:0] mant_n;
  logic [EXP_W:0]    exp_n;

  // S2 combinational results
  logic                     s2_ready;
  logic                     lsb, g, r, st, round_up;
  logic [SIG_W:0]           sig_r;
  logic signed [EXP_W+1:0]  exp_r;
  logic [FRAC_W-1:0]        frac;
  logic                     mant_zero, ovf, unf;
  logic [31:0]              res_data;
  flags_t                   res_flags;
  logic                     unused_sig_msb;

  // A stage advances when the next one is empty or emptying this cycle.
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  norm_shift #(
    .MANT_W (MANT_W),
    .LZ_W   (LZ_W)
  ) u_norm_shift (
    .mant   (in_mant),
    .lz     (lz),
    .mant_n (mant_n)
  );

  // Exponent widened by one bit so subtracting lz never wraps.
  assign exp_n = {in_exp[EXP_W-1], in_exp} - (EXP_W+1)'(lz);

  // S2 rounding: round to nearest, ties to even, with carry-out renormalization.
  always_comb begin
    lsb       = s1_mant[3];
    g         = s1_mant[2];
    r         = s1_mant[1];
    st        = s1_mant[0];
    round_up  = g & (r | st | lsb);
    sig_r     = {1'b0, s1_mant[MANT_W-1:3]} + (SIG_W+1)'(round_up);
    exp_r     = {s1_exp[EXP_W], s1_exp} + (EXP_W+2)'(sig_r[SIG_W]);
    frac      = sig_r[SIG_W-2 -: FRAC_W];
    mant_zero = ~|s1_mant;
    ovf       = !exp_r[EXP_W+1] && (exp_r >= EXP_OVF);
    unf       = exp_r[EXP_W+1] || (exp_r == '0);
  end

  // Carry-out leaves the implicit one at bit SIG_W; the hidden bit is never packed.
  assign unused_sig_msb = sig_r[SIG_W-1];

  // S2 packing with special-case priority nan > inf > zero, then range checks.
  always_comb begin
    res_data  = pack_f32(s1_sign, exp_r[7:0], frac);
    res_flags = flags_t'({2'b00, g | r | st});
    if (s1_nan) begin
      res_data  = QNAN;
      res_flags = flags_t'(3'b000);
    end else if (s1_inf) begin
      res_data  = pack_f32(s1_sign, 8'hFF, '0);
      res_flags = flags_t'(3'b000);
    end else if (s1_zero || mant_zero) begin
      res_data  = pack_f32(s1_sign, 8'h00, '0);
      res_flags = flags_t'(3'b000);
    end else if (ovf) begin
      res_data  = pack_f32(s1_sign, 8'hFF, '0);
      res_flags = flags_t'(3'b101);
    end else if (unf) begin
      res_data  = pack_f32(s1_sign, 8'h00, '0);
      res_flags = flags_t'(3'b011);
    end
  end

  // Pipeline valids and the registered output; reset discards in-flight items.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_ready) out_valid <= s1_valid;
      if (s1_valid && s2_ready) begin
        out_data  <= res_data;
        out_flags <= res_flags;
      end
    end
  end

  // S1 payload capture; qualified by s1_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sign <= in_sign;
      s1_nan  <= in_nan;
      s1_inf  <= in_inf;
      s1_zero <= in_zero;
      s1_exp  <= exp_n;
      s1_mant <= mant_n;
    end
  end

endmodule

// File: tb/tb_div_f_norm_pack.sv
// Self-checking bench: directed vector table, stall/reset sequences, random traffic vs a model.
module tb_div_f_norm_pack;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] mant;
    logic        nan;
    logic        inf;
    logic        zero;
  } vec_in_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  flags;
  } res_t;

  typedef struct {
    vec_in_t vin;
    res_t    want;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [26:0] in_mant;
  logic        in_nan, in_inf, in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  int   n_vec = 0;
  int   n_bad = 0;
  res_t exp_q[$];
  vec_t tbl[$];
  logic prev_stall = 1'b0;
  res_t prev_out;

  div_f_norm_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_nan    (in_nan),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic vec_in_t mkv(input logic s, input int e, input logic [26:0] m,
                                  input logic nan, input logic inf, input logic zero);
    vec_in_t v;
    v.sign = s; v.exp = 10'(e); v.mant = m; v.nan = nan; v.inf = inf; v.zero = zero;
    return v;
  endfunction

  task automatic add(input vec_in_t v, input logic [31:0] d, input logic [2:0] f);
    vec_t t;
    t.vin = v; t.want.data = d; t.want.flags = f;
    tbl.push_back(t);
  endtask

  // Reference: normalize by doubling, round with integer remainder, then range checks.
  function automatic res_t model(input vec_in_t v);
    res_t   res;
    longint m;
    int     e, rem;
    longint q;
    res.flags = 3'b000;
    if (v.nan) begin
      res.data = 32'h7FC00000; return res;
    end
    if (v.inf) begin
      res.data = {v.sign, 8'hFF, 23'h0}; return res;
    end
    if (v.zero || v.mant == 27'd0) begin
      res.data = {v.sign, 31'h0}; return res;
    end
    m = longint'(v.mant);
    e = int'($signed(v.exp));
    while (m < 64'd67108864) begin
      m = m * 2; e = e - 1;
    end
    q   = m / 8;
    rem = int'(m % 8);
    if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
    if (q == 64'd16777216) begin
      q = 64'd8388608; e = e + 1;
    end
    if (e >= 255) begin
      res.data = {v.sign, 8'hFF, 23'h0}; res.flags = 3'b101;
    end else if (e <= 0) begin
      res.data = {v.sign, 31'h0}; res.flags = 3'b011;
    end else begin
      res.data  = {v.sign, 8'(e), 23'(q)};
      res.flags = {2'b00, rem != 0};
    end
    return res;
  endfunction

  function automatic vec_in_t rand_vec();
    vec_in_t v;
    int      sel;
    v.sign = 1'($urandom);
    v.mant = 27'($urandom) >> $urandom_range(0, 27);
    sel = int'($urandom % 8);
    if (sel == 0)      v.exp = 10'(int'($urandom_range(0, 40)) - 20);
    else if (sel == 1) v.exp = 10'($urandom_range(250, 280));
    else               v.exp = 10'($urandom_range(60, 200));
    sel = int'($urandom % 16);
    v.nan  = (sel == 0);
    v.inf  = (sel == 1) || (sel == 0 && $urandom % 2 == 1);
    v.zero = (sel == 2) || (sel <= 1 && $urandom % 2 == 1);
    return v;
  endfunction

  task automatic drive(input vec_in_t v);
    in_sign = v.sign; in_exp = v.exp; in_mant = v.mant;
    in_nan = v.nan; in_inf = v.inf; in_zero = v.zero;
  endtask

  // One handshake cycle, entered and left at a falling edge, scoreboarded in order.
  task automatic cycle(input logic ov, input vec_in_t v, input logic ordy, output logic acc);
    res_t got, want;
    drive(v);
    in_valid  = ov;
    out_ready = ordy;
    #1;
    got.data = out_data; got.flags = out_flags;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_payload", 64'(got), 64'(prev_out));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_output: got %0h expected no item", got);
      end else begin
        want = exp_q.pop_front();
        chk("out_payload", 64'(got), 64'(want));
      end
    end
    acc = ov && in_ready;
    if (acc) exp_q.push_back(model(v));
    prev_stall = out_valid && !out_ready;
    prev_out   = got;
    @(negedge clk);
  endtask

  initial begin
    vec_in_t items[3];
    vec_in_t v;
    logic    acc, have, ordy;
    int      k;

    add(mkv(0, 127, 27'h4000000, 0, 0, 0), 32'h3F800000, 3'b000);
    add(mkv(0, 150, 27'h0000008, 0, 0, 0), 32'h3F800000, 3'b000);
    add(mkv(0, 127, 27'h7FFFFFF, 0, 0, 0), 32'h40000000, 3'b001);
    add(mkv(0, 255, 27'h4000000, 0, 0, 0), 32'h7F800000, 3'b101);
    add(mkv(0,   0, 27'h4000000, 0, 0, 0), 32'h00000000, 3'b011);
    add(mkv(1, 127, 27'h4000000, 0, 0, 0), 32'hBF800000, 3'b000);
    add(mkv(0, 127, 27'h4000000, 1, 1, 0), 32'h7FC00000, 3'b000);
    add(mkv(1, 127, 27'h4000000, 0, 1, 1), 32'hFF800000, 3'b000);
    add(mkv(1, 127, 27'h4000000, 0, 0, 1), 32'h80000000, 3'b000);
    add(mkv(0, 100, 27'h0000000, 0, 0, 0), 32'h00000000, 3'b000);
    add(mkv(0, 127, 27'h4000004, 0, 0, 0), 32'h3F800000, 3'b001);
    add(mkv(0, 127, 27'h400000C, 0, 0, 0), 32'h3F800002, 3'b001);
    add(mkv(0, 254, 27'h7FFFFFF, 0, 0, 0), 32'h7F800000, 3'b101);
    add(mkv(0,   1, 27'h4000000, 0, 0, 0), 32'h00800000, 3'b000);
    add(mkv(1,   1, 27'h2000000, 0, 0, 0), 32'h80000000, 3'b011);
    add(mkv(0,  -5, 27'h4000000, 0, 0, 0), 32'h00000000, 3'b011);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(mkv(0, 0, 27'h0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_flags", 64'(out_flags), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed vectors with exact two-edge latency.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vin);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("tbl%0d_lat1_valid", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_lat2_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].want.data));
      chk($sformatf("tbl%0d_flags", i), 64'(out_flags), 64'(tbl[i].want.flags));
      @(negedge clk);
    end

    // Stall with three offers: two buffered, third held off, then all three in order.
    items[0] = tbl[0].vin; items[1] = tbl[2].vin; items[2] = tbl[5].vin;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(k < 3, items[k < 3 ? k : 2], 1'b0, acc);
      if (acc) k++;
    end
    #1;
    chk("stall_accepted", 64'(k), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_out_data", 64'(out_data), 64'(tbl[0].want.data));
    for (int c = 0; c < 10; c++) begin
      cycle(k < 3, items[k < 3 ? k : 2], 1'b1, acc);
      if (acc) k++;
    end
    chk("stall_all_accepted", 64'(k), 64'd3);
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Reset during a full stall discards everything.
    k = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(k < 3, items[k < 3 ? k : 2], 1'b0, acc);
      if (acc) k++;
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_out_data", 64'(out_data), 64'd0);
    chk("rst_stall_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rst_no_stale", 64'(out_valid), 64'd0);
      cycle(1'b0, items[0], 1'b1, acc);
    end

    // Sustained throughput of one item per cycle.
    k = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, rand_vec(), 1'b1, acc);
      if (acc) k++;
    end
    chk("throughput", 64'(k), 64'd8);

    // Random traffic with random backpressure; an unaccepted offer is held.
    have = 1'b0;
    v    = rand_vec();
    for (int c = 0; c < 3000; c++) begin
      if (!have && ($urandom % 4 != 0)) begin
        v = rand_vec(); have = 1'b1;
      end
      ordy = ($urandom % 4) != 0;
      cycle(have, v, ordy, acc);
      if (acc) have = 1'b0;
    end
    for (int c = 0; c < 20; c++) cycle(1'b0, v, 1'b1, acc);
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
